cpu_main_controller: RTL and testbench
======================================

# cpu_main_controller

Main control decoder for the single-cycle MIPS-subset datapath. Takes the 6-bit instruction opcode and produces the register-file, ALU-source, memory, branch, jump and 2-bit ALUop control signals consumed by the datapath and the ALU control unit. Outputs are registered on the single system clock, and synchronous reset drives them to an all-zero NOP pattern.

## Interface

Parameters: none.

Ports:
- `clk` input 1: system clock; all state updates on the rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `OP` input 6: instruction opcode field, bits [31:26].
- `RegDst` output 1: 1 selects rd as the write register; 0 selects rt.
- `ALUsrcB` output 1: 1 selects the sign-extended immediate as ALU operand B; 0 selects rt data.
- `MemToReg` output 1: 1 selects data-memory read data for write-back; 0 selects the ALU result.
- `WriteReg` output 1: register-file write enable.
- `MemWrite` output 1: data-memory write enable.
- `Branch` output 1: conditional-branch (BEQ) indication to the PC logic.
- `ALUop1` output 1: ALUop bit 1.
- `ALUop0` output 1: ALUop bit 0.
- `JMP` output 1: unconditional-jump select to the PC logic.

## Operation

- The opcode is decoded into one of the classes R, LW, SW, BEQ, J or OTHER.
- The control vector is {RegDst, ALUsrcB, MemToReg, WriteReg, MemWrite, Branch, ALUop1, ALUop0, JMP}. Each class maps to one vector:
  - R, 000000: 1,0,0,1,0,0,1,0,0
  - LW, 100011: 0,1,1,1,0,0,0,0,0
  - SW, 101011: 0,1,0,0,1,0,0,0,0
  - BEQ, 000100: 0,0,0,0,0,1,0,1,0
  - J, 000010: 0,0,0,0,0,0,0,0,1
  - OTHER, any other opcode: all zeros (NOP). No register write, no memory write, no PC redirect.
- Textbook don't-cares (SW RegDst/MemToReg, BEQ RegDst/MemToReg, J everything) are fixed to 0 for determinism.
- At most one of WriteReg, MemWrite, Branch and JMP classes is active in any vector. MemWrite and WriteReg are never both 1.
- No other internal state exists.

## Timing

- On each rising `clk`:
  - If `rst_n` = 0, all nine outputs load 0.
  - Otherwise, outputs load the decoded vector of the `OP` value sampled at that edge.
- Latency is 1 cycle from `OP` to outputs. Outputs are stable for the whole following cycle and are glitch-free.
- `rst_n` is sampled only at clock edges. Asserting it mid-stream zeroes the outputs at the next edge, regardless of `OP`. On release, the first edge with `rst_n` = 1 loads the decode of the current `OP`.
- `OP` changing every cycle produces a new vector every cycle, with no hold or back-pressure.
- Outputs are undefined before the first clock edge. The system applies reset for at least 1 cycle at startup.

## Structure

- Shared package `cpu_ctrl_pkg` holds:
  - Opcode constants: OP_RTYPE = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011, OP_BEQ = 6'b000100, OP_J = 6'b000010.
  - ALUop constants: ALUOP_ADD = 2'b00, ALUOP_SUB = 2'b01, ALUOP_FUNCT = 2'b10.
  - A packed control-vector struct type with the nine fields in the order listed under Operation, plus a `CTRL_NOP` all-zero constant.
- One sub-module, `opcode_decoder`, is purely combinational: `OP` in, control struct out. The top level wraps it with the reset-capable output register and unpacks the fields to the ports.

## Test plan

- Reset: hold `rst_n` = 0 for 2 cycles with `OP` = 100011. All outputs must read 0. Release; one edge later the vector must be 0,1,1,1,0,0,0,0,0.
- Sequence with each `OP` held several cycles: 000000, then 100011, 101011, 000100, 000010. One cycle after each change, outputs must equal the R, LW, SW, BEQ and J vectors from Operation.
- Back-to-back: change `OP` every cycle through R, SW, J. Outputs must follow with exactly 1-cycle lag and no skipped or duplicated vectors.
- Unsupported opcodes 001000, 111111 and 000011 must each produce the all-zero vector.
- Mid-stream reset: with `OP` = 000000, assert `rst_n` = 0 for 1 cycle. Outputs must read 0 for that cycle, then return to 1,0,0,1,0,0,1,0,0.
- Exhaustive sweep of all 64 opcodes: exactly 5 produce a non-zero vector, and none produces WriteReg = MemWrite = 1.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: opcode, ALUop and control-vector types
// shared by the main controller and its decoder.
package cpu_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef enum logic [2:0] {
    CLS_R,
    CLS_LW,
    CLS_SW,
    CLS_BEQ,
    CLS_J,
    CLS_OTHER
  } opClass_t;

  typedef struct packed {
    logic regDst;
    logic aluSrcB;
    logic memToReg;
    logic writeReg;
    logic memWrite;
    logic branch;
    logic aluOp1;
    logic aluOp0;
    logic jmp;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  function automatic opClass_t classify(input logic [5:0] op);
    opClass_t c;
    c = CLS_OTHER;
    unique case (1'b1)
      (op == OP_RTYPE): c = CLS_R;
      (op == OP_LW):    c = CLS_LW;
      (op == OP_SW):    c = CLS_SW;
      (op == OP_BEQ):   c = CLS_BEQ;
      (op == OP_J):     c = CLS_J;
      default:          c = CLS_OTHER;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/cpu_main_controller_opcode_decoder.sv
// opcode_decoder: purely combinational opcode to
// control-vector mapping; unknown opcodes give NOP.
module opcode_decoder
  import cpu_ctrl_pkg::*;
(
  input  logic [5:0] OP,
  output ctrl_t      ctrl
);

  opClass_t cls;

  assign cls = classify(OP);

  // map each opcode class to its fixed control vector
  always_comb begin
    ctrl = CTRL_NOP;
    unique case (cls)
      CLS_R: begin
        ctrl.regDst   = 1'b1;
        ctrl.writeReg = 1'b1;
        {ctrl.aluOp1, ctrl.aluOp0} = ALUOP_FUNCT;
      end
      CLS_LW: begin
        ctrl.aluSrcB  = 1'b1;
        ctrl.memToReg = 1'b1;
        ctrl.writeReg = 1'b1;
        {ctrl.aluOp1, ctrl.aluOp0} = ALUOP_ADD;
      end
      CLS_SW: begin
        ctrl.aluSrcB  = 1'b1;
        ctrl.memWrite = 1'b1;
        {ctrl.aluOp1, ctrl.aluOp0} = ALUOP_ADD;
      end
      CLS_BEQ: begin
        ctrl.branch = 1'b1;
        {ctrl.aluOp1, ctrl.aluOp0} = ALUOP_SUB;
      end
      CLS_J: begin
        ctrl.jmp = 1'b1;
      end
      default: ctrl = CTRL_NOP;
    endcase
  end

endmodule

// File: rtl/cpu_main_controller.sv
// cpu_main_controller: registered main control decoder
// for the single-cycle MIPS-subset datapath.
module cpu_main_controller
  import cpu_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] OP,
  output logic       RegDst,
  output logic       ALUsrcB,
  output logic       MemToReg,
  output logic       WriteReg,
  output logic       MemWrite,
  output logic       Branch,
  output logic       ALUop1,
  output logic       ALUop0,
  output logic       JMP
);

  ctrl_t ctrlD;
  ctrl_t ctrlQ;

  opcode_decoder uDecoder (
    .OP   (OP),
    .ctrl (ctrlD)
  );

  // output register; reset loads the NOP vector
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrlQ <= CTRL_NOP;
    end else begin
      ctrlQ <= ctrlD;
    end
  end

  assign RegDst   = ctrlQ.regDst;
  assign ALUsrcB  = ctrlQ.aluSrcB;
  assign MemToReg = ctrlQ.memToReg;
  assign WriteReg = ctrlQ.writeReg;
  assign MemWrite = ctrlQ.memWrite;
  assign Branch   = ctrlQ.branch;
  assign ALUop1   = ctrlQ.aluOp1;
  assign ALUop0   = ctrlQ.aluOp0;
  assign JMP      = ctrlQ.jmp;

endmodule

// File: tb/tb_cpu_main_controller.sv
// tb_cpu_main_controller: randomized and directed checks
// of the main controller against a table model.
module tb_cpu_main_controller;

  logic       clk;
  logic       rst_n;
  logic [5:0] OP;
  logic       RegDst;
  logic       ALUsrcB;
  logic       MemToReg;
  logic       WriteReg;
  logic       MemWrite;
  logic       Branch;
  logic       ALUop1;
  logic       ALUop0;
  logic       JMP;
  logic [8:0] obs;

  int total;
  int bad;

  cpu_main_controller dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .OP       (OP),
    .RegDst   (RegDst),
    .ALUsrcB  (ALUsrcB),
    .MemToReg (MemToReg),
    .WriteReg (WriteReg),
    .MemWrite (MemWrite),
    .Branch   (Branch),
    .ALUop1   (ALUop1),
    .ALUop0   (ALUop0),
    .JMP      (JMP)
  );

  assign obs = {RegDst, ALUsrcB, MemToReg, WriteReg,
                MemWrite, Branch, ALUop1, ALUop0, JMP};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [8:0] model(input logic [5:0] op);
    if (op == 6'b000000) return 9'b1_0_0_1_0_0_1_0_0;
    if (op == 6'b100011) return 9'b0_1_1_1_0_0_0_0_0;
    if (op == 6'b101011) return 9'b0_1_0_0_1_0_0_0_0;
    if (op == 6'b000100) return 9'b0_0_0_0_0_1_0_1_0;
    if (op == 6'b000010) return 9'b0_0_0_0_0_0_0_0_1;
    return 9'b0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    OP = 6'b100011;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if (obs !== 9'b0) begin
        bad++;
        $display("FAIL reset_hold got=%b want=%b", obs, 9'b0);
      end
    end
    rst_n = 1'b1;
    tick();
    total++;
    if (obs !== 9'b0_1_1_1_0_0_0_0_0) begin
      bad++;
      $display("FAIL reset_release got=%b want=%b",
               obs, 9'b011100000);
    end
  endtask

  task automatic test_sequence();
    logic [5:0] ops [5];
    ops = '{6'b000000, 6'b100011, 6'b101011,
            6'b000100, 6'b000010};
    foreach (ops[k]) begin
      OP = ops[k];
      for (int c = 0; c < 3; c++) begin
        tick();
        total++;
        if (obs !== model(ops[k])) begin
          bad++;
          $display("FAIL seq op=%b got=%b want=%b",
                   ops[k], obs, model(ops[k]));
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] ops [3];
    logic [8:0] expQ [$];
    logic [8:0] exp;
    ops = '{6'b000000, 6'b101011, 6'b000010};
    for (int r = 0; r < 2; r++) begin
      foreach (ops[k]) begin
        OP = ops[k];
        expQ.push_back(model(ops[k]));
        tick();
        exp = expQ.pop_front();
        total++;
        if (obs !== exp) begin
          bad++;
          $display("FAIL b2b op=%b got=%b want=%b",
                   ops[k], obs, exp);
        end
      end
    end
  endtask

  task automatic test_unsupported();
    logic [5:0] ops [3];
    ops = '{6'b001000, 6'b111111, 6'b000011};
    foreach (ops[k]) begin
      OP = ops[k];
      tick();
      total++;
      if (obs !== 9'b0) begin
        bad++;
        $display("FAIL unsupported op=%b got=%b want=%b",
                 ops[k], obs, 9'b0);
      end
    end
  endtask

  task automatic test_midreset();
    OP = 6'b000000;
    tick();
    rst_n = 1'b0;
    tick();
    total++;
    if (obs !== 9'b0) begin
      bad++;
      $display("FAIL midreset_zero got=%b want=%b", obs, 9'b0);
    end
    rst_n = 1'b1;
    tick();
    total++;
    if (obs !== 9'b100100100) begin
      bad++;
      $display("FAIL midreset_back got=%b want=%b",
               obs, 9'b100100100);
    end
  endtask

  task automatic test_sweep();
    int nonZero;
    nonZero = 0;
    for (int v = 0; v < 64; v++) begin
      OP = 6'(v);
      tick();
      if (obs !== 9'b0) nonZero++;
      total++;
      if (obs !== model(6'(v))) begin
        bad++;
        $display("FAIL sweep op=%b got=%b want=%b",
                 6'(v), obs, model(6'(v)));
      end
      total++;
      if ((WriteReg & MemWrite) !== 1'b0) begin
        bad++;
        $display("FAIL sweep_wr_mw op=%b got=%b want=0",
                 6'(v), WriteReg & MemWrite);
      end
    end
    total++;
    if (nonZero != 5) begin
      bad++;
      $display("FAIL sweep_count got=%0d want=5", nonZero);
    end
  endtask

  task automatic test_random();
    logic [5:0] known [5];
    logic [8:0] expQ [$];
    logic [8:0] exp;
    logic [5:0] op;
    logic       rs;
    known = '{6'b000000, 6'b100011, 6'b101011,
              6'b000100, 6'b000010};
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(1, 0) == 1)
        op = known[$urandom_range(4, 0)];
      else
        op = 6'($urandom);
      rs = ($urandom_range(15, 0) != 0);
      OP = op;
      rst_n = rs;
      expQ.push_back(rs ? model(op) : 9'b0);
      tick();
      exp = expQ.pop_front();
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL random op=%b rst_n=%b got=%b want=%b",
                 op, rs, obs, exp);
      end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    OP = 6'b0;
    test_reset();
    test_sequence();
    test_back_to_back();
    test_unsupported();
    test_midreset();
    test_sweep();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
